uart_rx_bank: RTL and testbench
===============================

# uart_rx_bank

Parametrised multi-channel UART receiver for the SoC and its simulation harness. It decodes CHANNELS independent serial lines (e.g. o_io_tx / o_io_tx2 of SOC_TOP, or external rx pins) into parallel bytes. Each byte is presented on a per-channel valid/ready handshake, with optional parity and framing/overrun error reporting. Successor to the fixed two-line, 8N1-only hookup: channel count, frame format and baud divisor are generics.

## Interface
- CHANNELS, 2: number of independent receive lines (1..8).
- DATA_BITS, 8: data bits per frame (5..9), LSB first.
- CLKS_PER_BIT, 16: i_clk cycles per bit; even, >= 4.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_rx  in  CHANNELS  serial inputs, idle high, asynchronous to i_clk.
- o_valid  out  CHANNELS  byte available on channel n.
- i_ready  in  CHANNELS  consumer accepts channel n byte this cycle.
- o_data  out  CHANNELS*DATA_BITS  channel n byte at [n*DATA_BITS +: DATA_BITS].
- o_parity_err  out  CHANNELS  qualifies held byte; valid only while o_valid[n].
- o_frame_err  out  CHANNELS  qualifies held byte; valid only while o_valid[n].
- o_overrun  out  CHANNELS  one-cycle pulse: completed frame dropped.

## Operation
- Channels are fully independent. Each channel has:
  - a 2-flop synchroniser;
  - a bit-timer counter of $clog2(CLKS_PER_BIT) bits;
  - a bit counter;
  - a shift register;
  - a holding register.
- Per-channel FSM: IDLE, START, DATA, PAR, STOP, WAIT_IDLE.
  - IDLE: a synchronised low sample loads the timer with CLKS_PER_BIT/2-1 -> START.
  - START: on timer expiry, resample the line. High = false start -> IDLE, nothing reported. Low -> DATA, timer reloaded with CLKS_PER_BIT-1.
  - DATA: sample at each expiry and shift in LSB first. After DATA_BITS samples -> PAR if PARITY != 0, else STOP.
  - PAR: sample the parity bit. Parity error = XOR of data bits and parity bit != (PARITY==1 ? 1 : 0).
  - STOP: sample STOP_BITS stop bits, one per expiry. Any low stop sample sets frame error.
    - After the last stop sample, the frame completes.
    - No frame error -> IDLE. Frame error -> WAIT_IDLE.
  - WAIT_IDLE: stay until the synchronised line is high, then -> IDLE. This keeps a break condition from producing repeated 0x00 frames.
- Frame completion:
  - Holding register empty, or being drained this cycle (o_valid & i_ready): load byte and both error flags; o_valid=1 next cycle.
  - Otherwise: discard the new frame, keep the held byte, pulse o_overrun[n] for one cycle.
- Handshake: o_valid stays high and o_data/error flags stay stable until the cycle where i_ready is high; o_valid clears after that edge. Load and drain in the same cycle leaves o_valid high with the new byte.
- DATA_BITS < 9: unused high bits do not exist; the width is exact per parameter.
- Reset: all FSMs -> IDLE, counters 0, synchronisers preset to 1.
  - o_valid = 0, o_data = 0, o_parity_err = 0, o_frame_err = 0, o_overrun = 0.
  - Reset mid-frame aborts the frame with no output.

## Timing
- Sync latency: 2 cycles from i_rx to the FSM.
- Let T0 = first i_clk edge where the synchroniser output is low.
  - Start-bit check at T0 + CLKS_PER_BIT/2.
  - Data bit k is sampled at T0 + CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT.
- o_valid rises one cycle after the last stop-bit sample: T0 + CLKS_PER_BIT/2 + (DATA_BITS + (PARITY!=0) + STOP_BITS)*CLKS_PER_BIT + 1.
- Back-to-back frames: a new start edge is accepted from the cycle after the last stop sample. Minimum inter-frame idle is 0 bits.
- o_overrun pulses in the same cycle o_valid would have risen.
- Input bit-period tolerance: ±(CLKS_PER_BIT/2 - 1) cycles accumulated over one frame.

## Test plan
- Default params (2 ch, 8N1, CPB=16):
  - Drive 0xA5 on ch0, i_ready held 1 -> o_valid[0] is high for exactly 1 cycle, 2+8+9*16+1 = 155 cycles after the line falls, with o_data[7:0]=0xA5 and no errors. ch1 stays idle.
- False start: 6-cycle low glitch on ch1 -> no o_valid, FSM back in IDLE. A following 0x3C is received correctly.
- PARITY=2 (even):
  - 0x07 with parity bit 1 -> valid, o_parity_err=0.
  - 0x07 with parity bit 0 -> o_parity_err=1.
- Framing/break: ch0 held low for 20 bit times -> one byte 0x00 with o_frame_err=1. No further valid until the line returns high. The next frame 0x55 is clean.
- Overrun: i_ready=0, send 0x11 then 0x22 back-to-back -> 0x11 held, o_overrun[0] pulses once. Raising i_ready delivers 0x11 only.
- Both channels simultaneously with different bytes (0x81, 0x7E) and staggered ready, plus i_rst asserted mid-frame on a third transfer -> outputs zero, partial frame dropped, the next frame decodes.

Source files
------------

// File: rtl/uart_rx_bank.sv
// CHANNELS independent UART receivers. Each has a 2-flop synchroniser and is mid-bit sampled.
// o_valid rises one cycle after the last stop sample. A byte held on o_valid stalls the next frame, which is then dropped with an o_overrun pulse.
module uart_rx_bank #(
    parameter int CHANNELS     = 2,
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [CHANNELS-1:0]           i_rx,
    output logic [CHANNELS-1:0]           o_valid,
    input  logic [CHANNELS-1:0]           i_ready,
    output logic [CHANNELS*DATA_BITS-1:0] o_data,
    output logic [CHANNELS-1:0]           o_parity_err,
    output logic [CHANNELS-1:0]           o_frame_err,
    output logic [CHANNELS-1:0]           o_overrun
);
    localparam int TW  = $clog2(CLKS_PER_BIT);
    localparam int BCW = 4;
    localparam logic [TW-1:0]  HALF_RELOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]  BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] LAST_DATA   = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] LAST_STOP   = BCW'(STOP_BITS - 1);
    localparam logic           PAR_ODD     = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_IDLE
    } state_t;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic                 sync1, sync2;
        state_t               state, state_nx;
        logic [TW-1:0]        timer, timer_nx;
        logic [BCW-1:0]       bitcnt, bitcnt_nx;
        logic [DATA_BITS-1:0] shreg, shreg_nx;
        logic                 perr, perr_nx, ferr, ferr_nx;
        logic                 done, expired;
        logic [DATA_BITS-1:0] hold_data;
        logic                 hold_perr, hold_ferr, hold_vld, ovr;

        assign expired = (timer == '0);

        always_comb begin
            state_nx  = state;
            timer_nx  = timer;
            bitcnt_nx = bitcnt;
            shreg_nx  = shreg;
            perr_nx   = perr;
            ferr_nx   = ferr;
            done      = 1'b0;
            if (state != S_IDLE && state != S_WAIT_IDLE && !expired)
                timer_nx = timer - 1'b1;
            case (state)
                S_IDLE: begin
                    if (!sync2) begin
                        timer_nx = HALF_RELOAD;
                        state_nx = S_START;
                    end
                end
                S_START: begin
                    if (expired) begin
                        if (sync2) begin
                            state_nx = S_IDLE;
                        end else begin
                            state_nx  = S_DATA;
                            timer_nx  = BIT_RELOAD;
                            bitcnt_nx = '0;
                            perr_nx   = 1'b0;
                            ferr_nx   = 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (expired) begin
                        shreg_nx = {sync2, shreg[DATA_BITS-1:1]};
                        timer_nx = BIT_RELOAD;
                        if (bitcnt == LAST_DATA) begin
                            bitcnt_nx = '0;
                            state_nx  = (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            bitcnt_nx = bitcnt + 1'b1;
                        end
                    end
                end
                S_PAR: begin
                    if (expired) begin
                        perr_nx  = ((^shreg) ^ sync2) != PAR_ODD;
                        timer_nx = BIT_RELOAD;
                        state_nx = S_STOP;
                    end
                end
                S_STOP: begin
                    if (expired) begin
                        if (!sync2)
                            ferr_nx = 1'b1;
                        if (bitcnt == LAST_STOP) begin
                            done     = 1'b1;
                            state_nx = ferr_nx ? S_WAIT_IDLE : S_IDLE;
                        end else begin
                            bitcnt_nx = bitcnt + 1'b1;
                            timer_nx  = BIT_RELOAD;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    if (sync2)
                        state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                sync1     <= 1'b1;
                sync2     <= 1'b1;
                state     <= S_IDLE;
                timer     <= '0;
                bitcnt    <= '0;
                shreg     <= '0;
                perr      <= 1'b0;
                ferr      <= 1'b0;
                hold_data <= '0;
                hold_perr <= 1'b0;
                hold_ferr <= 1'b0;
                hold_vld  <= 1'b0;
                ovr       <= 1'b0;
            end else begin
                sync1  <= i_rx[n];
                sync2  <= sync1;
                state  <= state_nx;
                timer  <= timer_nx;
                bitcnt <= bitcnt_nx;
                shreg  <= shreg_nx;
                perr   <= perr_nx;
                ferr   <= ferr_nx;
                ovr    <= 1'b0;
                if (hold_vld && i_ready[n])
                    hold_vld <= 1'b0;
                // A drain in the same cycle frees the slot, so the new frame is not an overrun.
                if (done) begin
                    if (!hold_vld || i_ready[n]) begin
                        hold_vld  <= 1'b1;
                        hold_data <= shreg;
                        hold_perr <= perr;
                        hold_ferr <= ferr_nx;
                    end else begin
                        ovr <= 1'b1;
                    end
                end
            end
        end

        assign o_valid[n]                            = hold_vld;
        assign o_data[n*DATA_BITS +: DATA_BITS]      = hold_data;
        assign o_parity_err[n]                       = hold_perr;
        assign o_frame_err[n]                        = hold_ferr;
        assign o_overrun[n]                          = ovr;
    end
endmodule

// File: tb/tb_uart_rx_bank.sv
// Directed bench for uart_rx_bank: a default 2-channel 8N1 instance plus a 1-channel even-parity instance.
module tb_uart_rx_bank;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rx = 2'b11;
    logic [1:0]  ready = 2'b00;
    logic [1:0]  valid, perr, ferr, ovr;
    logic [15:0] data;
    logic [0:0]  p_rx = 1'b1;
    logic [0:0]  p_ready = 1'b1;
    logic [0:0]  p_valid, p_perr, p_ferr, p_ovr;
    logic [7:0]  p_data;

    int errors = 0;
    int checks = 0;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] qp[$];
    int ovr0 = 0;

    always #5 clk = ~clk;

    uart_rx_bank dut (
        .i_clk(clk), .i_rst(rst), .i_rx(rx), .o_valid(valid), .i_ready(ready),
        .o_data(data), .o_parity_err(perr), .o_frame_err(ferr), .o_overrun(ovr)
    );

    uart_rx_bank #(.CHANNELS(1), .PARITY(2)) dut_p (
        .i_clk(clk), .i_rst(rst), .i_rx(p_rx), .o_valid(p_valid), .i_ready(p_ready),
        .o_data(p_data), .o_parity_err(p_perr), .o_frame_err(p_ferr), .o_overrun(p_ovr)
    );

    // Records every accepted byte as {frame_err, parity_err, data}.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid[0] && ready[0]) q0.push_back({ferr[0], perr[0], data[7:0]});
            if (valid[1] && ready[1]) q1.push_back({ferr[1], perr[1], data[15:8]});
            if (p_valid[0] && p_ready[0]) qp.push_back({p_ferr[0], p_perr[0], p_data});
            if (ovr[0]) ovr0++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int line, input logic b);
        case (line)
            0: rx[0] = b;
            1: rx[1] = b;
            default: p_rx[0] = b;
        endcase
    endtask

    task automatic send_bits(input int line, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(line, bits[i]);
            repeat (16) tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (valid !== 2'b00) begin errors++; $display("FAIL reset_valid got %b exp 00", valid); end
        checks++; if (data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", data); end
        checks++; if ({perr, ferr, ovr} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b exp 000000", {perr, ferr, ovr}); end
        checks++; if ({p_valid, p_data, p_perr} !== 10'b0) begin errors++; $display("FAIL reset_par_inst got %h exp 000", {p_valid, p_data, p_perr}); end
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_latency();
        int first = -1;
        int high_cnt = 0;
        int v1 = 0;
        logic [9:0] got = 10'h3ff;
        ready = 2'b11;
        tick();
        fork
            send_bits(0, {1'b1, 8'hA5, 1'b0}, 10);
            begin
                for (int k = 1; k <= 200; k++) begin
                    tick();
                    if (valid[0]) begin
                        if (first < 0) begin
                            first = k;
                            got = {ferr[0], perr[0], data[7:0]};
                        end
                        high_cnt++;
                    end
                    if (valid[1]) v1++;
                end
            end
        join
        checks++; if (first !== 155) begin errors++; $display("FAIL latency got %0d exp 155", first); end
        checks++; if (high_cnt !== 1) begin errors++; $display("FAIL valid_width got %0d exp 1", high_cnt); end
        checks++; if (got !== 10'h0A5) begin errors++; $display("FAIL a5_byte got %h exp 0a5", got); end
        checks++; if (v1 !== 0) begin errors++; $display("FAIL ch1_idle got %0d exp 0", v1); end
    endtask

    task automatic test_false_start();
        int base = q1.size();
        rx[1] = 1'b0;
        repeat (6) tick();
        rx[1] = 1'b1;
        repeat (40) tick();
        checks++; if (q1.size() !== base) begin errors++; $display("FAIL glitch_no_byte got %0d exp %0d", q1.size(), base); end
        send_bits(1, {1'b1, 8'h3C, 1'b0}, 10);
        repeat (20) tick();
        checks++; if (q1.size() !== base + 1) begin errors++; $display("FAIL after_glitch_count got %0d exp %0d", q1.size(), base + 1); end
        if (q1.size() > base) begin
            checks++; if (q1[base] !== 10'h03C) begin errors++; $display("FAIL after_glitch_byte got %h exp 03c", q1[base]); end
        end
    endtask

    task automatic test_parity();
        int base = qp.size();
        send_bits(2, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
        send_bits(2, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
        repeat (20) tick();
        checks++; if (qp.size() !== base + 2) begin errors++; $display("FAIL parity_count got %0d exp %0d", qp.size(), base + 2); end
        if (qp.size() >= base + 2) begin
            checks++; if (qp[base] !== 10'h007) begin errors++; $display("FAIL parity_good got %h exp 007", qp[base]); end
            checks++; if (qp[base+1] !== 10'h107) begin errors++; $display("FAIL parity_bad got %h exp 107", qp[base+1]); end
        end
    endtask

    task automatic test_break();
        int base = q0.size();
        ready = 2'b11;
        rx[0] = 1'b0;
        repeat (320) tick();
        checks++; if (q0.size() !== base + 1) begin errors++; $display("FAIL break_count got %0d exp %0d", q0.size(), base + 1); end
        rx[0] = 1'b1;
        repeat (32) tick();
        checks++; if (q0.size() !== base + 1) begin errors++; $display("FAIL break_after_high got %0d exp %0d", q0.size(), base + 1); end
        if (q0.size() > base) begin
            checks++; if (q0[base] !== 10'h200) begin errors++; $display("FAIL break_byte got %h exp 200", q0[base]); end
        end
        send_bits(0, {1'b1, 8'h55, 1'b0}, 10);
        repeat (20) tick();
        checks++; if (q0.size() !== base + 2) begin errors++; $display("FAIL post_break_count got %0d exp %0d", q0.size(), base + 2); end
        if (q0.size() > base + 1) begin
            checks++; if (q0[base+1] !== 10'h055) begin errors++; $display("FAIL post_break_byte got %h exp 055", q0[base+1]); end
        end
    endtask

    task automatic test_overrun();
        int base = q0.size();
        int obase = ovr0;
        ready[0] = 1'b0;
        send_bits(0, {1'b1, 8'h11, 1'b0}, 10);
        send_bits(0, {1'b1, 8'h22, 1'b0}, 10);
        repeat (20) tick();
        checks++; if (ovr0 - obase !== 1) begin errors++; $display("FAIL overrun_pulses got %0d exp 1", ovr0 - obase); end
        checks++; if (valid[0] !== 1'b1) begin errors++; $display("FAIL overrun_held_valid got %b exp 1", valid[0]); end
        checks++; if (data[7:0] !== 8'h11) begin errors++; $display("FAIL overrun_held_data got %h exp 11", data[7:0]); end
        ready[0] = 1'b1;
        repeat (5) tick();
        checks++; if (q0.size() !== base + 1) begin errors++; $display("FAIL overrun_drain_count got %0d exp %0d", q0.size(), base + 1); end
        if (q0.size() > base) begin
            checks++; if (q0[base] !== 10'h011) begin errors++; $display("FAIL overrun_drain_byte got %h exp 011", q0[base]); end
        end
        checks++; if (valid[0] !== 1'b0) begin errors++; $display("FAIL overrun_valid_clear got %b exp 0", valid[0]); end
    endtask

    task automatic test_back_to_back_reset();
        int b0 = q0.size();
        int b1 = q1.size();
        ready = 2'b01;
        fork
            send_bits(0, {1'b1, 8'h81, 1'b0}, 10);
            send_bits(1, {1'b1, 8'h7E, 1'b0}, 10);
        join
        repeat (20) tick();
        checks++; if (q0.size() !== b0 + 1) begin errors++; $display("FAIL dual_ch0_count got %0d exp %0d", q0.size(), b0 + 1); end
        if (q0.size() > b0) begin
            checks++; if (q0[b0] !== 10'h081) begin errors++; $display("FAIL dual_ch0_byte got %h exp 081", q0[b0]); end
        end
        checks++; if (valid[1] !== 1'b1) begin errors++; $display("FAIL dual_ch1_held got %b exp 1", valid[1]); end
        checks++; if (data[15:8] !== 8'h7E) begin errors++; $display("FAIL dual_ch1_data got %h exp 7e", data[15:8]); end
        ready[1] = 1'b1;
        repeat (3) tick();
        checks++; if (q1.size() !== b1 + 1) begin errors++; $display("FAIL dual_ch1_count got %0d exp %0d", q1.size(), b1 + 1); end
        if (q1.size() > b1) begin
            checks++; if (q1[b1] !== 10'h07E) begin errors++; $display("FAIL dual_ch1_byte got %h exp 07e", q1[b1]); end
        end
        // Partial frame on ch0, then reset in the middle of it.
        rx[0] = 1'b0;
        repeat (40) tick();
        rst = 1'b1;
        rx[0] = 1'b1;
        repeat (3) tick();
        checks++; if (valid !== 2'b00) begin errors++; $display("FAIL midreset_valid got %b exp 00", valid); end
        checks++; if (data !== 16'h0000) begin errors++; $display("FAIL midreset_data got %h exp 0000", data); end
        rst = 1'b0;
        repeat (40) tick();
        checks++; if (q0.size() !== b0 + 1) begin errors++; $display("FAIL midreset_dropped got %0d exp %0d", q0.size(), b0 + 1); end
        send_bits(0, {1'b1, 8'h5A, 1'b0}, 10);
        repeat (20) tick();
        checks++; if (q0.size() !== b0 + 2) begin errors++; $display("FAIL post_reset_count got %0d exp %0d", q0.size(), b0 + 2); end
        if (q0.size() > b0 + 1) begin
            checks++; if (q0[b0+1] !== 10'h05A) begin errors++; $display("FAIL post_reset_byte got %h exp 05a", q0[b0+1]); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_false_start();
        test_parity();
        test_break();
        test_overrun();
        test_back_to_back_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
